// File: rtl/dbus_req_buffer.sv
// Purpose: buffers the Memory-stage data request and holds it on dbus through the addr_ok/data_ok handshake.
// Latency: dreq.valid 1 cycle after m_dreq.valid in IDLE; response to Memory 1 cycle after dbus data_ok.
// Backpressure: stall is held until the response is in DONE; DONE persists until advance.
//
// Ports (flattened bus records):
//   clk, reset            clock and synchronous active-high reset
//   m_dreq  [71:0]  in    {valid, addr[31:0], size[2:0], strobe[3:0], data[31:0]} from Memory
//   m_dresp [33:0]  out   {addr_ok, data_ok, data[31:0]} registered response to Memory
//   dreq    [71:0]  out   request to dbus, same layout as m_dreq
//   dresp   [33:0]  in    response from dbus, same layout as m_dresp
//   advance         in    Memory-stage instruction retires this cycle
//   stall           out   stall request to the hazard unit
//   misalign        out   current request was misaligned (meaningful in DONE only)
// Size encoding: 0 = MSIZE1, 1 = MSIZE2, 2 = MSIZE4.
module dbus_req_buffer #(
    parameter logic ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [71:0] m_dreq,
    output logic [33:0] m_dresp,
    output logic [71:0] dreq,
    input  logic [33:0] dresp,
    input  logic        advance,
    output logic        stall,
    output logic        misalign
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;

    logic        m_valid;
    logic [31:0] m_addr;
    logic [2:0]  m_size;
    logic [3:0]  m_strobe;
    logic [31:0] m_data;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    assign m_valid     = m_dreq[71];
    assign m_addr      = m_dreq[70:39];
    assign m_size      = m_dreq[38:36];
    assign m_strobe    = m_dreq[35:32];
    assign m_data      = m_dreq[31:0];
    assign bus_addr_ok = dresp[33];
    assign bus_data_ok = dresp[32];
    assign bus_rdata   = dresp[31:0];

    logic [1:0]  state;
    logic [31:0] buf_addr;
    logic [2:0]  buf_size;
    logic [3:0]  buf_strobe;
    logic [31:0] buf_data;
    logic [31:0] resp_data;
    logic        mis_q;
    logic        aligned;

    always_comb begin
        aligned = 1'b1;
        case (m_size)
            MSIZE2:  aligned = ~m_addr[0];
            MSIZE4:  aligned = (m_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            buf_addr   <= '0;
            buf_size   <= '0;
            buf_strobe <= '0;
            buf_data   <= '0;
            resp_data  <= '0;
            mis_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_valid) begin
                        buf_addr   <= m_addr;
                        buf_size   <= m_size;
                        buf_strobe <= m_strobe;
                        buf_data   <= m_data;
                        if (ALIGN_CHECK && !aligned) begin
                            // Never reaches the bus; answer Memory directly with zero data.
                            resp_data <= '0;
                            mis_q     <= 1'b1;
                            state     <= DONE;
                        end else begin
                            mis_q <= 1'b0;
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_addr_ok && bus_data_ok) begin
                        resp_data <= bus_rdata;
                        state     <= DONE;
                    end else if (bus_addr_ok) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_data_ok) begin
                        resp_data <= bus_rdata;
                        state     <= DONE;
                    end
                end
                default: begin
                    // DONE: Memory keeps valid high for stores, so only advance
                    // may leave; this is what keeps a store from being re-issued.
                    if (advance) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Outputs are decoded from state, so the bus request drops in the same
    // cycle reset is applied and no dresp path reaches dreq combinationally.
    always_comb begin
        dreq     = {(state == REQ) && !reset, buf_addr, buf_size, buf_strobe, buf_data};
        m_dresp  = '0;
        stall    = 1'b0;
        misalign = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: stall = m_valid;
                REQ:  stall = 1'b1;
                WAIT: stall = 1'b1;
                default: begin
                    m_dresp  = {2'b11, resp_data};
                    misalign = mis_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_req_buffer.sv
module tb_dbus_req_buffer;

    logic        clk;
    logic        reset;
    logic [71:0] m_dreq;
    logic [33:0] m_dresp;
    logic [71:0] dreq;
    logic [33:0] dresp;
    logic        advance;
    logic        stall;
    logic        misalign;

    logic        m_valid;
    logic [31:0] m_addr;
    logic [2:0]  m_size;
    logic [3:0]  m_strobe;
    logic [31:0] m_data;
    logic        b_addr_ok;
    logic        b_data_ok;
    logic [31:0] b_data;

    assign m_dreq = {m_valid, m_addr, m_size, m_strobe, m_data};
    assign dresp  = {b_addr_ok, b_data_ok, b_data};

    int passed = 0;
    int total  = 0;
    int issues = 0;
    int base;
    logic [71:0] held;

    dbus_req_buffer #(.ALIGN_CHECK(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .m_dreq   (m_dreq),
        .m_dresp  (m_dresp),
        .dreq     (dreq),
        .dresp    (dresp),
        .advance  (advance),
        .stall    (stall),
        .misalign (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Bus-request counter and hazard-unit protocol check, sampled mid-cycle.
    always @(negedge clk) begin
        if (dreq[71] === 1'b1) issues++;
        if (advance === 1'b1) chk("advance_while_stall", {71'd0, stall}, 72'd0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic [2:0] s,
                           input logic [3:0] st, input logic [31:0] d);
        m_valid = v; m_addr = a; m_size = s; m_strobe = st; m_data = d;
    endtask

    task automatic set_bus(input logic aok, input logic dok, input logic [31:0] d);
        b_addr_ok = aok; b_data_ok = dok; b_data = d;
    endtask

    initial begin
        reset = 1'b1; advance = 1'b0;
        set_req(1'b0, 32'h0, 3'd0, 4'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0);
        cyc(); cyc();

        // Reset state
        settle();
        chk("rst_dreq", dreq, 72'd0);
        chk("rst_m_dresp", {38'd0, m_dresp}, 72'd0);
        chk("rst_stall", {71'd0, stall}, 72'd0);
        chk("rst_misalign", {71'd0, misalign}, 72'd0);
        reset = 1'b0;
        cyc();

        // 1: load word, zero-wait bus
        base = issues;
        set_req(1'b1, 32'h8000_0010, 3'd2, 4'h0, 32'h0);
        settle();
        chk("lw_idle_stall", {71'd0, stall}, 72'd1);
        chk("lw_idle_dreq_vld", {71'd0, dreq[71]}, 72'd0);
        cyc();
        set_bus(1'b1, 1'b1, 32'hDEAD_BEEF);
        settle();
        chk("lw_req_dreq", dreq, {1'b1, 32'h8000_0010, 3'd2, 4'h0, 32'h0});
        chk("lw_req_stall", {71'd0, stall}, 72'd1);
        chk("lw_req_m_dresp", {38'd0, m_dresp}, 72'd0);
        cyc();
        set_bus(1'b0, 1'b0, 32'h0);
        settle();
        chk("lw_done_m_dresp", {38'd0, m_dresp}, {38'd0, 2'b11, 32'hDEAD_BEEF});
        chk("lw_done_stall", {71'd0, stall}, 72'd0);
        chk("lw_done_dreq_vld", {71'd0, dreq[71]}, 72'd0);
        advance = 1'b1; m_valid = 1'b0;
        cyc();
        advance = 1'b0;
        settle();
        chk("lw_idle_m_dresp", {38'd0, m_dresp}, 72'd0);
        chk("lw_issue_cnt", 72'(issues - base), 72'd1);

        // 2: split handshake
        base = issues;
        set_req(1'b1, 32'h8000_0020, 3'd2, 4'h0, 32'h0);
        cyc();
        settle();
        held = dreq;
        chk("split_req1", held, {1'b1, 32'h8000_0020, 3'd2, 4'h0, 32'h0});
        m_addr = 32'hFFFF_FFFC; // Memory-side changes must not leak onto the bus
        cyc();
        settle();
        chk("split_req2", dreq, held);
        cyc();
        set_bus(1'b1, 1'b0, 32'h0);
        settle();
        chk("split_req3", dreq, held);
        cyc();
        set_bus(1'b0, 1'b0, 32'h0);
        settle();
        chk("split_wait_vld", {71'd0, dreq[71]}, 72'd0);
        chk("split_wait_stall", {71'd0, stall}, 72'd1);
        cyc();
        settle();
        chk("split_wait2_stall", {71'd0, stall}, 72'd1);
        cyc();
        set_bus(1'b0, 1'b1, 32'h1234_5678);
        settle();
        chk("split_wait3_stall", {71'd0, stall}, 72'd1);
        chk("split_wait3_m_dresp", {38'd0, m_dresp}, 72'd0);
        cyc();
        set_bus(1'b0, 1'b0, 32'h0);
        settle();
        chk("split_done_m_dresp", {38'd0, m_dresp}, {38'd0, 2'b11, 32'h1234_5678});
        chk("split_done_stall", {71'd0, stall}, 72'd0);
        advance = 1'b1; m_valid = 1'b0;
        cyc();
        advance = 1'b0;
        chk("split_issue_cycles", 72'(issues - base), 72'd3);

        // 3: store byte held in DONE by external stall
        base = issues;
        set_req(1'b1, 32'h8000_0103, 3'd0, 4'b1000, 32'hAB00_0000);
        cyc();
        set_bus(1'b1, 1'b1, 32'h0);
        settle();
        chk("sb_req_dreq", dreq, {1'b1, 32'h8000_0103, 3'd0, 4'b1000, 32'hAB00_0000});
        cyc();
        set_bus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("sb_hold_m_dresp", {38'd0, m_dresp}, {38'd0, 2'b11, 32'h0});
            chk("sb_hold_dreq_vld", {71'd0, dreq[71]}, 72'd0);
            chk("sb_hold_stall", {71'd0, stall}, 72'd0);
            cyc();
        end
        advance = 1'b1; m_valid = 1'b0;
        cyc();
        advance = 1'b0;
        settle();
        chk("sb_after_adv_m_dresp", {38'd0, m_dresp}, 72'd0);
        chk("sb_issue_cnt", 72'(issues - base), 72'd1);

        // 4: misaligned halfword, then misaligned word
        base = issues;
        set_req(1'b1, 32'h8000_0201, 3'd1, 4'b0000, 32'h0);
        settle();
        chk("lh_mis_idle_stall", {71'd0, stall}, 72'd1);
        set_bus(1'b1, 1'b1, 32'h5555_5555); // ignored: not in REQ/WAIT
        cyc();
        set_bus(1'b0, 1'b0, 32'h0);
        settle();
        chk("lh_mis_flag", {71'd0, misalign}, 72'd1);
        chk("lh_mis_m_dresp", {38'd0, m_dresp}, {38'd0, 2'b11, 32'h0});
        chk("lh_mis_stall", {71'd0, stall}, 72'd0);
        advance = 1'b1;
        set_req(1'b0, 32'h0, 3'd0, 4'h0, 32'h0);
        cyc();
        advance = 1'b0;
        settle();
        chk("lh_mis_cleared", {71'd0, misalign}, 72'd0);
        set_req(1'b1, 32'h8000_0202, 3'd2, 4'h0, 32'h0);
        cyc();
        settle();
        chk("lw_mis_flag", {71'd0, misalign}, 72'd1);
        advance = 1'b1; m_valid = 1'b0;
        cyc();
        advance = 1'b0;
        chk("mis_issue_cnt", 72'(issues - base), 72'd0);

        // 5: back-to-back LW then SW
        base = issues;
        set_req(1'b1, 32'h8000_0300, 3'd2, 4'h0, 32'h0);
        cyc();
        set_bus(1'b1, 1'b1, 32'h1111_2222);
        cyc();
        set_bus(1'b0, 1'b0, 32'h0);
        settle();
        chk("b2b_done1", {38'd0, m_dresp}, {38'd0, 2'b11, 32'h1111_2222});
        advance = 1'b1;
        cyc();
        advance = 1'b0;
        set_req(1'b1, 32'h8000_0304, 3'd2, 4'hF, 32'h5566_7788);
        settle();
        chk("b2b_idle_vld", {71'd0, dreq[71]}, 72'd0);
        chk("b2b_idle_stall", {71'd0, stall}, 72'd1);
        cyc();
        set_bus(1'b1, 1'b1, 32'h0);
        settle();
        chk("b2b_sw_dreq", dreq, {1'b1, 32'h8000_0304, 3'd2, 4'hF, 32'h5566_7788});
        cyc();
        set_bus(1'b0, 1'b0, 32'h0);
        settle();
        chk("b2b_done2_stall", {71'd0, stall}, 72'd0);
        advance = 1'b1; m_valid = 1'b0;
        cyc();
        advance = 1'b0;
        chk("b2b_issue_cnt", 72'(issues - base), 72'd2);

        // 6: reset during WAIT, late data_ok ignored
        set_req(1'b1, 32'h8000_0400, 3'd2, 4'h0, 32'h0);
        cyc();
        set_bus(1'b1, 1'b0, 32'h0);
        cyc();
        set_bus(1'b0, 1'b0, 32'h0);
        settle();
        chk("rstw_wait_stall", {71'd0, stall}, 72'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        m_valid = 1'b0;
        set_bus(1'b0, 1'b1, 32'hBAD0_BAD0);
        settle();
        chk("rstw_dreq", dreq, 72'd0);
        chk("rstw_m_dresp", {38'd0, m_dresp}, 72'd0);
        chk("rstw_stall", {71'd0, stall}, 72'd0);
        cyc();
        set_bus(1'b0, 1'b0, 32'h0);
        settle();
        chk("rstw_late_m_dresp", {38'd0, m_dresp}, 72'd0);
        chk("rstw_late_stall", {71'd0, stall}, 72'd0);
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dbus_req_buffer.md
Name: dbus_req_buffer

Overview:
- Sits between the Memory stage and the data bus (dbus).
- Registers the Memory stage's combinational `dreq` and holds it stable on the bus through the `addr_ok`/`data_ok` handshake.
- Returns a registered, single-beat response to Memory and drives the pipeline stall request.
- Breaks the combinational path dresp → Memory `valid` → dreq, and guarantees each store is issued exactly once.

Parameters:
- ALIGN_CHECK, 1, when 1 a misaligned request is not issued to the bus and is flagged on `misalign`.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m_dreq  in  dbus_req_t (valid, addr[31:0], size msize_t, strobe[3:0], data[31:0])  request from the Memory stage.
- m_dresp  out  dbus_resp_t (addr_ok, data_ok, data[31:0])  registered response to the Memory stage.
- dreq  out  dbus_req_t  request to the data bus.
- dresp  in  dbus_resp_t  response from the data bus.
- advance  in  1  pipeline moves this cycle; the Memory-stage instruction retires to Writeback.
- stall  out  1  stall request to the hazard unit.
- misalign  out  1  current request is misaligned; valid in DONE only.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset sends the FSM to IDLE.
- Reset values: `dreq` = 0, `m_dresp` = 0, `stall` = 0, `misalign` = 0, buffer registers = 0.
- IDLE:
  - `dreq.valid` = 0.
  - If `m_dreq.valid`: latch addr/size/strobe/data into the buffer.
    - Aligned request → REQ.
    - Misaligned request with ALIGN_CHECK=1 → DONE with data = 0 and `misalign` = 1.
  - `stall` = `m_dreq.valid`.
- Alignment rule: MSIZE2 requires addr[0] = 0; MSIZE4 requires addr[1:0] = 0; MSIZE1 is always aligned.
- REQ:
  - `dreq` = buffer with `valid` = 1. Fields must not change while waiting.
  - `addr_ok` & `data_ok` in the same cycle → capture `dresp.data`, go to DONE.
  - `addr_ok` only → WAIT.
  - Neither → stay in REQ.
  - `stall` = 1.
- WAIT:
  - `dreq.valid` = 0.
  - On `data_ok` → capture data, go to DONE.
  - `stall` = 1.
- DONE:
  - `m_dresp` = {addr_ok = 1, data_ok = 1, data = captured data}; `stall` = 0.
  - `advance` → IDLE. Otherwise hold in DONE with the response unchanged.
  - Nothing is re-issued in DONE, even though Memory keeps `valid` = 1 for stores.
- `m_dresp` = 0 in all states other than DONE.
- Latency:
  - First `dreq.valid` appears 1 cycle after `m_dreq.valid` is seen in IDLE.
  - Response reaches Memory 1 cycle after the bus `data_ok`.
  - Minimum request-to-response is 3 cycles.
- Stores: `data_ok` is required before DONE. The captured data is don't-care, but is stored anyway.
- `dresp` arriving in IDLE or DONE is ignored.
- DONE with `advance` → IDLE.
  - An `m_dreq` valid in the following cycle belongs to the next instruction and starts a new transaction.
  - There is no back-to-back issue within the same cycle.
- Reset mid-transaction: IDLE on the next edge and `dreq.valid` drops immediately. The bus is reset by the same reset, so there is no drain.
- `advance` while not in DONE: ignored by the FSM.
  - The hazard unit must not assert `advance` while `stall` = 1.
  - The bench asserts this as a protocol check.

Test Plan:
- Load word, bus zero-wait: `m_dreq` {valid, addr=0x8000_0010, MSIZE4} with `addr_ok`=`data_ok`=1 and data 0xDEAD_BEEF in the first REQ cycle → `dreq.valid` for exactly 1 cycle; `m_dresp.data_ok`=1 with data 0xDEAD_BEEF on cycle 3; `stall` 1,1,0.
- Split handshake: `addr_ok` after 2 REQ cycles, `data_ok` 3 cycles later → `dreq` fields constant for all 3 REQ cycles; `dreq.valid`=0 during WAIT; `stall` released only in DONE.
- Store held by external stall: SB to addr 0x...03 with strobe 4'b1000 and data 0xAB00_0000; `advance`=0 for 4 cycles in DONE while `m_dreq` stays valid → exactly one bus request; DONE holds; IDLE after `advance`.
- Misaligned: LH at 0x...01 with ALIGN_CHECK=1 → no `dreq.valid`; DONE next cycle with `misalign`=1, data 0.
- Back-to-back: LW then SW with `advance` in the DONE cycle → second transaction's `dreq.valid` 2 cycles after the first DONE; each address issued once.
- Reset during WAIT → next cycle state IDLE with `dreq`, `m_dresp`, `stall` all 0; a late `data_ok` is ignored.
